// File: rtl/cg_mon_pkg.sv
// ============================================================================
// cg_mon_pkg : state encoding, flag bit indices and record width for the
//              coil-gun shot monitor.                       Rev 1.0
// ============================================================================
`default_nettype none

package cg_mon_pkg;

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_ON     = 3'd1;
  localparam logic [2:0] c_ST_GAP    = 3'd2;
  localparam logic [2:0] c_ST_EXT    = 3'd3;
  localparam logic [2:0] c_ST_COMMIT = 3'd4;

  localparam int c_FLG_SAT   = 0;
  localparam int c_FLG_NOEXT = 1;

  // Record layout is {flags[1:0], ext_time[CW-1:0], soe_time[CW-1:0]}.
  function automatic int rec_width(input int cw);
    return 2 * cw + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cg_mon_fifo.sv
// ============================================================================
// cg_mon_fifo : first-word fall-through FIFO with push, pop, full, empty and
//               level outputs; head reads zero while empty.     Rev 1.0
// ============================================================================
`default_nettype none

module cg_mon_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_empty = (o_level == '0);
  assign o_full  = (o_level == (c_AW + 1)'(DEPTH));

  // A pop frees the slot in the same edge, so a full FIFO still accepts a push.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_din;
  end

  assign o_dout = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/cg_shot_monitor.sv
// ============================================================================
// cg_shot_monitor : measures solenoid on-time and extraction time of each
//                   coil-gun shot and queues one record per shot.
//                   Optional macro CG_MON_SYNC_EN adds two-flop input
//                   synchronizers on I_SOE / I_EXT.            Rev 1.0
// ============================================================================
`default_nettype none

module cg_shot_monitor
  import cg_mon_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CW      = 24,
  parameter int GAP_MAX = 1000
) (
  input  logic                      clk,
  input  logic                      I_RST,
  input  logic                      I_SOE,
  input  logic                      I_EXT,
  input  logic                      I_ARM,
  input  logic                      I_POP,
  output logic                      O_VLD,
  output logic [CW-1:0]             O_SOE_T,
  output logic [CW-1:0]             O_EXT_T,
  output logic [1:0]                O_FLG,
  output logic [$clog2(DEPTH):0]    O_LVL,
  output logic                      O_OVF
);

  localparam int                c_RW       = rec_width(CW);
  localparam int                c_GW       = $clog2(GAP_MAX + 1);
  localparam logic [c_GW-1:0]   c_GAP_LAST = c_GW'(GAP_MAX);

  logic            w_soe;
  logic            w_ext;
  logic            r_soe_d;
  logic            w_soe_rise;
  logic [2:0]      r_state;
  logic [CW-1:0]   r_soe_cnt;
  logic [CW-1:0]   r_ext_cnt;
  logic [c_GW-1:0] r_gap_cnt;
  logic [1:0]      r_flg;
  logic            w_push;
  logic            w_full;
  logic            w_empty;
  logic            r_ovf;
  logic [c_RW-1:0] w_rec_in;
  logic [c_RW-1:0] w_rec_out;

`ifdef CG_MON_SYNC_EN
  logic [1:0] r_soe_sync;
  logic [1:0] r_ext_sync;

  always_ff @(posedge clk) begin
    if (I_RST) begin
      r_soe_sync <= '0;
      r_ext_sync <= '0;
    end else begin
      r_soe_sync <= {r_soe_sync[0], I_SOE};
      r_ext_sync <= {r_ext_sync[0], I_EXT};
    end
  end

  assign w_soe = r_soe_sync[1];
  assign w_ext = r_ext_sync[1];
`else
  assign w_soe = I_SOE;
  assign w_ext = I_EXT;
`endif

  always_ff @(posedge clk) begin
    if (I_RST) r_soe_d <= 1'b0;
    else       r_soe_d <= w_soe;
  end

  assign w_soe_rise = w_soe & ~r_soe_d;

  // Counters clamp at all-ones; an increment attempted there marks saturation.
  always_ff @(posedge clk) begin
    if (I_RST) begin
      r_state   <= c_ST_IDLE;
      r_soe_cnt <= '0;
      r_ext_cnt <= '0;
      r_gap_cnt <= '0;
      r_flg     <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_soe_rise && I_ARM) begin
            r_state   <= c_ST_ON;
            r_soe_cnt <= CW'(1);
            r_ext_cnt <= '0;
            r_gap_cnt <= '0;
            r_flg     <= '0;
          end
        end
        c_ST_ON: begin
          if (w_soe) begin
            if (r_soe_cnt == '1) r_flg[c_FLG_SAT] <= 1'b1;
            else                 r_soe_cnt <= r_soe_cnt + 1'b1;
          end else if (w_ext) begin
            r_state   <= c_ST_EXT;
            r_ext_cnt <= CW'(1);
          end else begin
            r_state   <= c_ST_GAP;
            r_gap_cnt <= c_GW'(1);
          end
        end
        c_ST_GAP: begin
          if (w_ext) begin
            r_state   <= c_ST_EXT;
            r_ext_cnt <= CW'(1);
          end else if (r_gap_cnt == c_GAP_LAST) begin
            r_state            <= c_ST_COMMIT;
            r_flg[c_FLG_NOEXT] <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        c_ST_EXT: begin
          if (w_ext) begin
            if (r_ext_cnt == '1) r_flg[c_FLG_SAT] <= 1'b1;
            else                 r_ext_cnt <= r_ext_cnt + 1'b1;
          end else begin
            r_state <= c_ST_COMMIT;
          end
        end
        c_ST_COMMIT: r_state <= c_ST_IDLE;
        default:     r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign w_push   = (r_state == c_ST_COMMIT);
  assign w_rec_in = {r_flg, r_ext_cnt, r_soe_cnt};

  cg_mon_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_RW)
  ) u_fifo (
    .clk     (clk),
    .rst     (I_RST),
    .i_push  (w_push),
    .i_pop   (I_POP),
    .i_din   (w_rec_in),
    .o_dout  (w_rec_out),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (O_LVL)
  );

  always_ff @(posedge clk) begin
    if (I_RST)                                   r_ovf <= 1'b0;
    else if (w_push && w_full && !(I_POP && !w_empty)) r_ovf <= 1'b1;
  end

  assign O_VLD   = ~w_empty;
  assign O_OVF   = r_ovf;
  assign O_SOE_T = w_rec_out[CW-1:0];
  assign O_EXT_T = w_rec_out[2*CW-1:CW];
  assign O_FLG   = w_rec_out[2*CW+1:2*CW];

endmodule

`default_nettype wire

// File: doc/cg_shot_monitor.md
CG_SHOT_MONITOR -- requirements
Module: cg_shot_monitor

Interface
REQ-001 Parameter DEPTH, default 4: record FIFO depth; power of two, 2..16.
REQ-002 Parameter CW, default 24: counter and record field width.
REQ-003 Parameter GAP_MAX, default 1000: maximum cycles from SOE low to EXT high before the shot is closed.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 I_RST  in  1  reset; synchronous, active-high.
REQ-006 I_SOE  in  1  solenoid-enable line from the coil core.
REQ-007 I_EXT  in  1  extraction line from the coil core.
REQ-008 I_ARM  in  1  capture enable; new shots start only while high.
REQ-009 I_POP  in  1  consumer ready; pops head record when O_VLD high.
REQ-010 O_VLD  out  1  FIFO non-empty; head record valid.
REQ-011 O_SOE_T  out  CW  head record: solenoid on-time in cycles.
REQ-012 O_EXT_T  out  CW  head record: extraction time in cycles.
REQ-013 O_FLG  out  2  head record flags: bit0 saturated, bit1 no-extract.
REQ-014 O_LVL  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-015 O_OVF  out  1  sticky: a record was dropped on a full FIFO.

Function
REQ-016 States IDLE, ON, GAP, EXT, COMMIT; one-hot or binary encoding from package.
REQ-017 IDLE->ON when sampled SOE goes 0->1 with I_ARM=1; the soe counter loads 1 in that cycle.
REQ-018 ON: soe counter +1 per cycle SOE=1; when SOE=0, go to EXT if EXT=1, else GAP.
REQ-019 GAP: gap counter +1 per cycle; EXT=1 -> EXT with ext counter loaded 1; gap counter = GAP_MAX -> COMMIT with flag bit1 set, ext time 0.
REQ-020 EXT: ext counter +1 per cycle EXT=1; EXT=0 -> COMMIT.
REQ-021 COMMIT lasts exactly one cycle; the FIFO write takes effect on the following edge, and O_VLD rises the cycle after COMMIT if FIFO was empty; then IDLE.
REQ-022 Counters saturate at all-ones; any saturation sets flag bit0; no wrap.
REQ-023 SOE rising edge while not IDLE is ignored; no nested shot.
REQ-024 I_ARM falling mid-shot does not abort; the shot completes and is recorded.
REQ-025 Write when full with no pop: record dropped, O_OVF set, FIFO unchanged.
REQ-026 Write and pop in the same cycle on a full FIFO: both succeed, O_LVL unchanged.
REQ-027 Pop when O_VLD=0 is ignored; O_LVL never underflows.
REQ-028 Head outputs are first-word fall-through; they hold while O_VLD=1 and I_POP=0.

Reset
REQ-029 I_RST=1 at an edge: state IDLE, all counters 0, FIFO empty, O_VLD=0, O_LVL=0, O_OVF=0, head outputs 0.
REQ-030 Reset mid-shot discards the partial shot; no record is written.
REQ-031 O_OVF clears only on reset.

Configuration
REQ-032 With CG_MON_SYNC_EN defined, I_SOE and I_EXT pass through two-flop synchronizers, adding 2 cycles latency to all state transitions.
REQ-033 Without CG_MON_SYNC_EN, inputs are sampled directly by a single edge-detect register; the inputs must be synchronous to clk.

Structure
REQ-034 Package cg_mon_pkg holds the state encoding, flag bit indices and the record width (2*CW+2).
REQ-035 Sub-module cg_mon_fifo implements a parameterized FWFT FIFO with push, pop, full, empty and level outputs.

Verification
REQ-036 SOE high 10 cycles, EXT high 5 cycles immediately after -> one record: SOE_T=10, EXT_T=5, FLG=0.
REQ-037 SOE high 3 cycles, EXT never rises, GAP_MAX=20 -> record SOE_T=3, EXT_T=0, FLG=2'b10, O_VLD rises 2 cycles after the gap count reaches 20.
REQ-038 DEPTH=4, five shots, no pops -> O_LVL=4, O_OVF=1, head is shot 1.
REQ-039 FIFO full, shot commits in the same cycle as I_POP=1 -> O_LVL stays 4, O_OVF stays 0.
REQ-040 CW=8, SOE high 300 cycles -> SOE_T=255, FLG bit0=1.
REQ-041 I_RST pulsed in the 5th cycle of EXT -> no record, O_LVL=0, state IDLE.
